aes_full_seq: RTL and testbench

Round sequencer for full AES-128 block encryption on the shared AES engine (aes_ctrl plus its encryption and key-generation datapath). It accepts one block request at a time over a valid/ready handshake. It drives the initial key whitening, then alternates AESKEYGENASSIST and AESENC/AESENCLAST single-round operations for rounds 1..10, supplying the matching Rcon. It waits on the engine's completion strobes between operations and reports done or error to the host.

---
 rtl/aes_full_seq.sv | 166 ++++++++++++++++
 tb/tb_aes_full_seq.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_full_seq.sv
// aes_full_seq: round sequencer that walks the shared AES engine through one AES-128 block encryption.
// Optional engine-wait watchdog: define AES_SEQ_TIMEOUT_EN (limit set by TIMEOUT).
package aes_pkg;
  typedef enum logic [2:0] {
    NOOP            = 3'd0,
    AESENC          = 3'd1,
    AESENCLAST      = 3'd2,
    AESDEC          = 3'd3,
    AESDECLAST      = 3'd4,
    AESKEYGENASSIST = 3'd5,
    AESIMC          = 3'd6
  } opcode;
endpackage

module aes_full_seq #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic           abort_i,
  output logic           whiten_o,
  output logic           eng_start_o,
  output aes_pkg::opcode eng_opcode_o,
  output logic [7:0]     eng_rcon_o,
  output logic [3:0]     round_o,
  input  logic           eng_key_ready_i,
  input  logic           eng_cipher_ready_i,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o
);
  import aes_pkg::*;

  typedef enum logic [2:0] {
    IDLE, WHITEN, KEY_ISSUE, KEY_WAIT, ENC_ISSUE, ENC_WAIT, DONE, ERR
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  state_t     state, state_nxt;
  logic [3:0] round, round_nxt;
  logic       timeout_hit;

  if (TIMEOUT < 4 || TIMEOUT > 255) begin : g_bad_timeout
    $error("aes_full_seq: TIMEOUT must lie in 4..255");
  end

  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

`ifdef AES_SEQ_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt;
  logic       in_wait;

  assign in_wait = (state == KEY_WAIT) || (state == ENC_WAIT);

  // wait_cnt counts completed wait cycles; it reaches TIMEOUT on the edge that leaves for ERR.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)        wait_cnt <= '0;
    else if (in_wait) wait_cnt <= wait_cnt + 8'd1;
    else              wait_cnt <= '0;
  end

  assign timeout_hit = in_wait && (wait_cnt == WAIT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      round <= '0;
    end else begin
      state <= state_nxt;
      round <= round_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    state_nxt = state;
    round_nxt = round;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          state_nxt = WHITEN;
          round_nxt = '0;
        end
      end
      WHITEN: begin
        state_nxt = KEY_ISSUE;
        round_nxt = 4'd1;
      end
      KEY_ISSUE: state_nxt = KEY_WAIT;
      KEY_WAIT: begin
        if (eng_key_ready_i)  state_nxt = ENC_ISSUE;
        else if (timeout_hit) state_nxt = ERR;
      end
      ENC_ISSUE: state_nxt = ENC_WAIT;
      ENC_WAIT: begin
        if (eng_cipher_ready_i) begin
          if (round == LAST_ROUND) begin
            state_nxt = DONE;
          end else begin
            state_nxt = KEY_ISSUE;
            round_nxt = round + 4'd1;
          end
        end else if (timeout_hit) begin
          state_nxt = ERR;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (abort_i && state != IDLE) begin
      state_nxt = IDLE;
      round_nxt = '0;
    end
  end

  // abort_i is the one input allowed to reach outputs: it squashes this cycle's start/done/err.
  assign eng_start_o = ((state == KEY_ISSUE) || (state == ENC_ISSUE)) && !abort_i;

  always_comb begin
    eng_opcode_o = NOOP;
    if (eng_start_o) begin
      if (state == KEY_ISSUE)        eng_opcode_o = AESKEYGENASSIST;
      else if (round == LAST_ROUND)  eng_opcode_o = AESENCLAST;
      else                           eng_opcode_o = AESENC;
    end
  end

  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign whiten_o    = (state == WHITEN);
  assign done_o      = (state == DONE) && !abort_i;
  assign round_o     = round;
  assign eng_rcon_o  = rcon_of(round);

`ifdef AES_SEQ_TIMEOUT_EN
  assign err_o = (state == ERR) && !abort_i;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_aes_full_seq.sv
// Bench for aes_full_seq: behavioural AES engine plus a scoreboard of expected operations and results.
module tb_aes_full_seq;
  import aes_pkg::*;

  localparam int           TIMEOUT = 8;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [7:0] RCON_T [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                           8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  logic clk = 1'b0, nrst = 1'b0, req_valid = 1'b0, abort = 1'b0;
  logic key_ready = 1'b0, cipher_ready = 1'b0;
  logic req_ready, whiten, eng_start, busy, done, err;
  opcode eng_opcode;
  logic [7:0] eng_rcon;
  logic [3:0] round;

  aes_full_seq #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .nrst(nrst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .abort_i(abort), .whiten_o(whiten), .eng_start_o(eng_start), .eng_opcode_o(eng_opcode),
    .eng_rcon_o(eng_rcon), .round_o(round), .eng_key_ready_i(key_ready),
    .eng_cipher_ready_i(cipher_ready), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { opcode op; logic [7:0] rcon; int rnd; } op_t;
  typedef struct { int at; logic [127:0] ct; } done_t;
  op_t   op_q[$];
  int    whiten_q[$];
  done_t done_q[$];

  int total = 0, bad = 0;
  int accept_cnt = 0, done_cnt = 0, err_cnt = 0;
  int last_accept = 0, last_err = 0;
  int n_keygen = 0, n_enc = 0, n_last = 0;
  int key_delay = 2, key_at = -1, cipher_at = -1, spur_at = -1;
  bit withhold_key = 1'b0;
  logic [127:0] eng_state, eng_key;

  // ---------------- reference AES arithmetic for the engine model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv, p;
    inv = 8'h01; p = a;
    for (int i = 1; i < 8; i++) begin   // a^254 = a^(2+4+...+128)
      p   = gmul(p, p);
      inv = gmul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input bit last);
    logic [7:0] b[16], t[16], o[16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) t[w+4*c] = b[w+4*((c+w)%4)];
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int w = 0; w < 4; w++) o[w+4*c] = t[w+4*c];
      end else begin
        o[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
        o[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
        o[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
        o[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = o[i];
    return r ^ k;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {w3[23:0], w3[31:24]};
    t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // ---------------- engine model and scoreboard monitor (samples on falling edge) ----------------
  task automatic monitor();
    op_t e;
    done_t d;
    int w;
    forever begin
      @(negedge clk);
      key_ready    = (cyc == key_at);
      cipher_ready = (cyc == cipher_at) || (cyc == spur_at);

      if (nrst && req_valid && req_ready) begin
        accept_cnt++;
        last_accept = cyc;
        whiten_q.push_back(cyc + 1);
        for (int r = 1; r <= 10; r++) begin
          op_q.push_back('{AESKEYGENASSIST, RCON_T[r], r});
          op_q.push_back('{(r == 10) ? AESENCLAST : AESENC, RCON_T[r], r});
        end
        done_q.push_back('{cyc + 2 + 10 * (key_delay + 5), CT});
      end

      if (whiten) begin
        total++;
        if (whiten_q.size() == 0) begin
          bad++; $display("FAIL whiten_unexpected cycle=%0d", cyc);
        end else begin
          w = whiten_q.pop_front();
          if (cyc !== w) begin bad++; $display("FAIL whiten_cycle got=%0d exp=%0d", cyc, w); end
        end
        eng_state = PT ^ KEY;
        eng_key   = KEY;
      end

      if (eng_start) begin
        total++;
        if (op_q.size() == 0) begin
          bad++; $display("FAIL start_unexpected op=%s cycle=%0d", eng_opcode.name(), cyc);
        end else begin
          e = op_q.pop_front();
          if (eng_opcode !== e.op || eng_rcon !== e.rcon || round !== 4'(e.rnd)) begin
            bad++;
            $display("FAIL start_op got=%s/%h/r%0d exp=%s/%h/r%0d", eng_opcode.name(), eng_rcon,
                     round, e.op.name(), e.rcon, e.rnd);
          end
        end
        case (eng_opcode)
          AESKEYGENASSIST: begin
            n_keygen++;
            eng_key = key_next(eng_key, eng_rcon);
            key_at  = withhold_key ? -1 : cyc + key_delay;
          end
          AESENC: begin
            n_enc++;
            eng_state = aes_round(eng_state, eng_key, 1'b0);
            cipher_at = cyc + 3;
          end
          AESENCLAST: begin
            n_last++;
            eng_state = aes_round(eng_state, eng_key, 1'b1);
            cipher_at = cyc + 3;
          end
          default: ;
        endcase
      end

      if (done) begin
        done_cnt++;
        total++;
        if (done_q.size() == 0) begin
          bad++; $display("FAIL done_unexpected cycle=%0d", cyc);
        end else begin
          d = done_q.pop_front();
          if (cyc !== d.at || eng_state !== d.ct) begin
            bad++;
            $display("FAIL done_result got=%0d/%h exp=%0d/%h", cyc, eng_state, d.at, d.ct);
          end
        end
      end

      if (err) begin
        err_cnt++;
        last_err = cyc;
      end
    end
  endtask

  task automatic flush();
    op_q.delete(); whiten_q.delete(); done_q.delete();
  endtask

  task automatic issue_request();
    int n0;
    n0 = accept_cnt;
    @(posedge clk); #1 req_valid = 1'b1;
    for (int i = 0; i < 10 && accept_cnt == n0; i++) begin @(negedge clk); #1; end
    total++;
    if (accept_cnt == n0) begin bad++; $display("FAIL accept_timeout got=0 exp=1"); end
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input int n_target, input int bound);
    for (int i = 0; i < bound && done_cnt < n_target; i++) begin @(negedge clk); #1; end
    total++;
    if (done_cnt < n_target) begin
      bad++; $display("FAIL done_timeout got=%0d exp=%0d", done_cnt, n_target);
    end
  endtask

  task automatic wait_start(input opcode op, input int rnd, output int k);
    k = -1;
    for (int i = 0; i < 200 && k < 0; i++) begin
      @(negedge clk); #1;
      if (eng_start && eng_opcode == op && round == 4'(rnd)) k = cyc;
    end
    total++;
    if (k < 0) begin bad++; $display("FAIL start_wait op=%s round=%0d not seen", op.name(), rnd); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1 || round !== 4'd0 || eng_rcon !== 8'h00) begin
      bad++; $display("FAIL reset_regs got=%b/%0d/%h exp=1/0/00", req_ready, round, eng_rcon);
    end
    total++;
    if (eng_opcode !== NOOP) begin bad++; $display("FAIL reset_opcode got=%s exp=NOOP", eng_opcode.name()); end
    total++;
    if ({whiten, eng_start, busy, done, err} !== 5'b0) begin
      bad++; $display("FAIL reset_pulses got=%b exp=00000", {whiten, eng_start, busy, done, err});
    end
    @(posedge clk); #1 nrst = 1'b1;
  endtask

  task automatic test_single();
    int d0, k0, e0, l0;
    d0 = done_cnt; k0 = n_keygen; e0 = n_enc; l0 = n_last;
    issue_request();
    wait_done(d0 + 1, 100);
    total++;
    if (n_keygen - k0 != 10 || n_enc - e0 != 9 || n_last - l0 != 1) begin
      bad++; $display("FAIL single_op_mix got=%0d/%0d/%0d exp=10/9/1", n_keygen - k0, n_enc - e0, n_last - l0);
    end
    @(negedge clk); #1;
    total++;
    if (done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL single_after_done got=%b%b%b exp=010", done, req_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    int a0, d0, first, idle_seen;
    a0 = accept_cnt; d0 = done_cnt; idle_seen = 0;
    @(posedge clk); #1 req_valid = 1'b1;
    for (int i = 0; i < 10 && accept_cnt == a0; i++) begin @(negedge clk); #1; end
    first = last_accept;
    for (int i = 0; i < 200 && accept_cnt < a0 + 2; i++) begin
      @(negedge clk); #1;
      if (!busy) idle_seen++;
    end
    @(posedge clk); #1 req_valid = 1'b0;
    total++;
    if (accept_cnt != a0 + 2 || last_accept - first != 73) begin
      bad++; $display("FAIL b2b_period got=%0d exp=73", last_accept - first);
    end
    total++;
    if (idle_seen != 1) begin bad++; $display("FAIL b2b_idle_cycles got=%0d exp=1", idle_seen); end
    wait_done(d0 + 2, 200);
  endtask

  task automatic test_key_stall();
    int d0, k;
    d0 = done_cnt;
    key_delay = 5;
    issue_request();
    wait_start(AESKEYGENASSIST, 3, k);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      total++;
      if (eng_start !== 1'b0 || round !== 4'd3) begin
        bad++; $display("FAIL stall_hold got=%b/r%0d exp=0/r3", eng_start, round);
      end
    end
    @(negedge clk); #1;
    total++;
    if (eng_start !== 1'b1 || eng_opcode !== AESENC) begin
      bad++; $display("FAIL stall_release got=%b/%s exp=1/AESENC", eng_start, eng_opcode.name());
    end
    wait_done(d0 + 1, 200);
    key_delay = 2;
  endtask

  task automatic test_abort();
    int d0, k;
    d0 = done_cnt;
    issue_request();
    wait_start(AESENC, 4, k);
    @(posedge clk); #1 abort = 1'b1;
    flush();
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk); #1;
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || round !== 4'd0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_idle got=%b%b/r%0d/%b exp=10/r0/0", req_ready, busy, round, done);
    end
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || round !== 4'd0 || done_cnt != d0) begin
      bad++; $display("FAIL abort_stray_ready got=%b/r%0d/%0d exp=0/r0/%0d", busy, round, done_cnt, d0);
    end
    // abort while the key issue is on the bus squashes the start strobe
    issue_request();
    @(posedge clk); #1 abort = 1'b1;
    #1;
    total++;
    if (eng_start !== 1'b0 || eng_opcode !== NOOP) begin
      bad++; $display("FAIL abort_squash got=%b/%s exp=0/NOOP", eng_start, eng_opcode.name());
    end
    flush();
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk); #1;
    total++;
    if (req_ready !== 1'b1 || round !== 4'd0) begin
      bad++; $display("FAIL abort_issue_idle got=%b/r%0d exp=1/r0", req_ready, round);
    end
    issue_request();
    wait_done(d0 + 1, 100);
  endtask

  task automatic test_spurious();
    int d0, k;
    d0 = done_cnt;
    issue_request();
    wait_start(AESKEYGENASSIST, 2, k);
    spur_at = k + 1;
    wait_done(d0 + 1, 100);
    spur_at = -1;
  endtask

  task automatic test_timeout();
    int d0, e0, k;
    d0 = done_cnt; e0 = err_cnt;
    withhold_key = 1'b1;
    issue_request();
    wait_start(AESKEYGENASSIST, 1, k);
`ifdef AES_SEQ_TIMEOUT_EN
    for (int i = 0; i < 20 && err_cnt == e0; i++) begin @(negedge clk); #1; end
    total++;
    if (err_cnt != e0 + 1 || last_err - k != TIMEOUT + 1) begin
      bad++; $display("FAIL timeout_err got=%0d exp=%0d", last_err - k, TIMEOUT + 1);
    end
    @(negedge clk); #1;
    total++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done_cnt != d0) begin
      bad++; $display("FAIL timeout_idle got=%b%b/%0d exp=10/%0d", req_ready, busy, done_cnt, d0);
    end
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      total++;
      if (err !== 1'b0 || busy !== 1'b1 || round !== 4'd1 || eng_start !== 1'b0) begin
        bad++; $display("FAIL wait_forever got=%b%b/r%0d/%b exp=01/r1/0", err, busy, round, eng_start);
      end
    end
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk); #1;
    total++;
    if (req_ready !== 1'b1 || err_cnt != e0) begin
      bad++; $display("FAIL wait_abort got=%b/%0d exp=1/%0d", req_ready, err_cnt, e0);
    end
`endif
    flush();
    withhold_key = 1'b0;
    key_at = -1;
  endtask

  initial begin
    fork monitor(); join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_key_stall();
    test_abort();
    test_spurious();
    test_timeout();
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (op_q.size() != 0 || done_q.size() != 0 || whiten_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain got=%0d/%0d/%0d exp=0/0/0", op_q.size(), done_q.size(), whiten_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
